// File: rtl/dbus_responder_pkg.sv
// dbus_responder_pkg
// Shared types for the data-bus responder slice:
//   msize_t      access size encoding carried on the request
//   dbus_req_t   request from the initiator (valid, addr, size, strobe, data)
//   dbus_resp_t  response to the initiator (addr_ok, data_ok, data)
//   state_t      responder FSM states
//   word_idx_t   RAM word index for the default array depth
//   is_misaligned() checks the low address bits against the access size
package dbus_responder_pkg;

  localparam int DBUS_MEM_WORDS = 4096;
  localparam logic [63:0] DBUS_BASE_ADDR = 64'h8000_0000;

  typedef enum logic [2:0] {
    MSIZE1 = 3'd0,
    MSIZE2 = 3'd1,
    MSIZE4 = 3'd2,
    MSIZE8 = 3'd3
  } msize_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
    msize_t      size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
  } dbus_resp_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef logic [$clog2(DBUS_MEM_WORDS)-1:0] word_idx_t;

  // An access is misaligned when any address bit below its natural size is set.
  // Unknown size codes are treated as full-word accesses.
  function automatic logic is_misaligned(input logic [2:0] lowAddr, input msize_t size);
    logic result;
    case (size)
      MSIZE1:  result = 1'b0;
      MSIZE2:  result = lowAddr[0];
      MSIZE4:  result = |lowAddr[1:0];
      MSIZE8:  result = |lowAddr;
      default: result = |lowAddr;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/dbus_responder_if.sv
// dbus_responder_if
// Bundles the data-bus request/response pair plus the error qualifier.
//   dreq      request, driven by the initiator
//   dresp     response, driven by the responder
//   resp_err  qualifies dresp.data_ok as an error response
// Modports: master (initiator side), slave (responder side).
interface dbus_responder_if;
  import dbus_responder_pkg::*;

  dbus_req_t  dreq;
  dbus_resp_t dresp;
  logic       resp_err;

  modport master (output dreq, input dresp, input resp_err);
  modport slave  (input dreq, output dresp, output resp_err);

endinterface

// File: rtl/dbus_mem_array.sv
// dbus_mem_array
// Storage-only backing RAM for the responder: 64-bit words, one port,
// synchronous byte-lane writes and asynchronous read of the addressed word.
//   clk       clock
//   i_we      write enable for this cycle
//   i_strobe  per-byte-lane write mask
//   i_idx     word index (read and write)
//   i_wdata   write data, byte lane i in bits [8i+7:8i]
//   o_rdata   current contents of word i_idx (pre-write during a write cycle)
module dbus_mem_array #(
  parameter int WORDS = 4096,
  parameter int IDXW  = $clog2(WORDS)
) (
  input  logic            clk,
  input  logic            i_we,
  input  logic [7:0]      i_strobe,
  input  logic [IDXW-1:0] i_idx,
  input  logic [63:0]     i_wdata,
  output logic [63:0]     o_rdata
);

  logic [63:0] r_mem [WORDS];

  // Each enabled lane lands in place; unselected lanes keep their old bytes.
  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int lane = 0; lane < 8; lane++) begin
        if (i_strobe[lane]) begin
          r_mem[i_idx][lane*8 +: 8] <= i_wdata[lane*8 +: 8];
        end
      end
    end
  end

  assign o_rdata = r_mem[i_idx];

endmodule

// File: rtl/dbus_responder.sv
// dbus_responder
// Data-bus slave answering dreq/dresp from a 64-bit-word RAM. A request is
// latched in IDLE, waits LATENCY cycles, then is answered for one cycle in
// RESP with addr_ok/data_ok, read data (pre-write word for writes) and
// resp_err for out-of-range or misaligned accesses.
//   clk    clock
//   reset  synchronous, active-high reset
//   bus    slave side of dbus_responder_if (dreq in; dresp, resp_err out)
// Parameters: MEM_WORDS (power of two, >= 2), LATENCY (0..15), BASE_ADDR.
// Optional macro DBUS_RESPONDER_RANDOM_DELAY_EN: adds 0..3 pseudo-random wait
// cycles per transaction from a 16-bit Galois LFSR seeded at reset.
module dbus_responder
  import dbus_responder_pkg::*;
#(
  parameter int          MEM_WORDS = DBUS_MEM_WORDS,
  parameter int          LATENCY   = 2,
  parameter logic [63:0] BASE_ADDR = DBUS_BASE_ADDR
) (
  input logic             clk,
  input logic             reset,
  dbus_responder_if.slave bus
);

  localparam int IdxW = $clog2(MEM_WORDS);

  state_t          r_state;
  state_t          w_nextState;
  logic [4:0]      r_count;
  logic [4:0]      w_nextCount;
  logic [4:0]      w_loadCount;
  logic            w_accept;
  logic [63:0]     r_addr;
  msize_t          r_size;
  logic [7:0]      r_strobe;
  logic [63:0]     r_data;
  logic [63:0]     w_offset;
  logic            w_inRange;
  logic            w_err;
  logic [IdxW-1:0] w_idx;
  logic [63:0]     w_rdata;
  logic            w_we;

`ifdef DBUS_RESPONDER_RANDOM_DELAY_EN
  logic [15:0] r_lfsr;

  // Right-shifting Galois LFSR for x^16+x^14+x^13+x^11+1; free-runs from the
  // reset seed so the extra-delay sequence repeats after every reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_lfsr <= 16'hACE1;
    end else begin
      r_lfsr <= {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);
    end
  end

  assign w_loadCount = 5'(LATENCY) + {3'b000, r_lfsr[1:0]};
`else
  assign w_loadCount = 5'(LATENCY);
`endif

  // Decode works on the latched address only. The subtraction stays 64 bits
  // wide so addresses below BASE_ADDR or far above the array cannot alias
  // into it; the index is truncated only after the range test.
  always_comb begin
    w_offset  = r_addr - BASE_ADDR;
    w_inRange = (r_addr >= BASE_ADDR) && ((w_offset >> 3) < 64'(MEM_WORDS));
    w_idx     = w_offset[IdxW+2:3];
    w_err     = !w_inRange || is_misaligned(r_addr[2:0], r_size);
  end

  // State and wait counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_count <= 5'd0;
    end else begin
      r_state <= w_nextState;
      r_count <= w_nextCount;
    end
  end

  // The request is captured once at accept; later changes on dreq are ignored
  // until the FSM is back in IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_addr   <= '0;
      r_size   <= MSIZE1;
      r_strobe <= '0;
      r_data   <= '0;
    end else if (w_accept) begin
      r_addr   <= bus.dreq.addr;
      r_size   <= bus.dreq.size;
      r_strobe <= bus.dreq.strobe;
      r_data   <= bus.dreq.data;
    end
  end

  // Next-state logic. WAIT lasts as many cycles as the loaded count, so a
  // zero count skips straight to RESP. RESP never accepts, which produces the
  // one-cycle IDLE bubble between transactions.
  always_comb begin
    w_nextState = r_state;
    w_nextCount = r_count;
    w_accept    = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.dreq.valid) begin
          w_accept    = 1'b1;
          w_nextCount = w_loadCount;
          w_nextState = (w_loadCount == 5'd0) ? RESP : WAIT;
        end
      end
      WAIT: begin
        w_nextCount = r_count - 5'd1;
        if (r_count <= 5'd1) begin
          w_nextState = RESP;
        end
      end
      RESP: begin
        w_nextState = IDLE;
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // Response outputs and the RAM write both come from RESP. Reset masks them
  // so a transaction caught by reset neither answers nor writes.
  always_comb begin
    bus.dresp.addr_ok = 1'b0;
    bus.dresp.data_ok = 1'b0;
    bus.dresp.data    = '0;
    bus.resp_err      = 1'b0;
    w_we              = 1'b0;
    if (r_state == RESP && !reset) begin
      bus.dresp.addr_ok = 1'b1;
      bus.dresp.data_ok = 1'b1;
      bus.resp_err      = w_err;
      bus.dresp.data    = w_err ? 64'd0 : w_rdata;
      w_we              = !w_err && (r_strobe != 8'h00);
    end
  end

  dbus_mem_array #(
    .WORDS (MEM_WORDS),
    .IDXW  (IdxW)
  ) u_mem (
    .clk      (clk),
    .i_we     (w_we),
    .i_strobe (r_strobe),
    .i_idx    (w_idx),
    .i_wdata  (r_data),
    .o_rdata  (w_rdata)
  );

endmodule

// File: tb/tb_dbus_responder.sv
// tb_dbus_responder
// Scoreboard bench for dbus_responder: each request pushes its expected
// response, and a negedge monitor pops and compares on every data_ok.
// Honours DBUS_RESPONDER_RANDOM_DELAY_EN for the latency expectations.
module tb_dbus_responder;
  import dbus_responder_pkg::*;

  localparam int          LATENCY   = 2;
  localparam int          MEM_WORDS = 4096;
  localparam logic [63:0] BASE      = 64'h8000_0000;

  typedef struct {
    logic [63:0] data;
    logic        err;
    logic        chkData;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  exp_t expQ[$];
  exp_t monExp;
  int   totalChecks = 0;
  int   passedChecks = 0;
  int   lastLatency = 0;
  int   latRunA[$];
  int   latRunB[$];

  always #5 clk = ~clk;

  dbus_responder_if bus ();

  dbus_responder #(
    .MEM_WORDS (MEM_WORDS),
    .LATENCY   (LATENCY),
    .BASE_ADDR (BASE)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    totalChecks++;
    if (observed === expected) begin
      passedChecks++;
    end else begin
      $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
    end
  endtask

  // Monitor: every data_ok pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (bus.dresp.data_ok) begin
      checkOutput("scoreboard has entry at data_ok", 64'(expQ.size() != 0), 64'd1);
      if (expQ.size() != 0) begin
        monExp = expQ.pop_front();
        checkOutput("addr_ok with data_ok", 64'(bus.dresp.addr_ok), 64'd1);
        checkOutput("resp_err", 64'(bus.resp_err), 64'(monExp.err));
        if (monExp.chkData) begin
          checkOutput("resp data", bus.dresp.data, monExp.data);
        end
      end
    end
  end

  task automatic doReset();
    @(negedge clk);
    reset = 1'b1;
    bus.dreq = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Drives one request, holds it until data_ok, and checks the latency.
  task automatic applyStimulus(input string tag, input logic [63:0] addr, input msize_t size,
                               input logic [7:0] strobe, input logic [63:0] data,
                               input logic [63:0] expData, input logic expErr, input logic chkData);
    int cycles;
    cycles = 0;
    expQ.push_back('{data: expData, err: expErr, chkData: chkData});
    @(negedge clk);
    bus.dreq.valid  = 1'b1;
    bus.dreq.addr   = addr;
    bus.dreq.size   = size;
    bus.dreq.strobe = strobe;
    bus.dreq.data   = data;
    do begin
      @(negedge clk);
      cycles++;
    end while (!bus.dresp.data_ok && cycles < 40);
    bus.dreq.valid = 1'b0;
    lastLatency = cycles;
`ifdef DBUS_RESPONDER_RANDOM_DELAY_EN
    checkOutput({tag, " latency in 3..6"}, 64'(cycles >= 3 && cycles <= 6), 64'd1);
`else
    checkOutput({tag, " latency"}, 64'(cycles), 64'(LATENCY + 1));
`endif
  endtask

  initial begin
    int pulses;
    int cycles;
    int lastPulse;
    int rstOks;

    bus.dreq = '0;
    doReset();
    checkOutput("reset addr_ok", 64'(bus.dresp.addr_ok), 64'd0);
    checkOutput("reset data_ok", 64'(bus.dresp.data_ok), 64'd0);
    checkOutput("reset data", bus.dresp.data, 64'd0);
    checkOutput("reset resp_err", 64'(bus.resp_err), 64'd0);

    $display("[TB] full write and read-back");
    applyStimulus("t1 write", 64'h8000_0010, MSIZE8, 8'hFF, 64'h1122_3344_5566_7788, 64'd0, 1'b0, 1'b0);
    applyStimulus("t1 read", 64'h8000_0010, MSIZE8, 8'h00, 64'd0, 64'h1122_3344_5566_7788, 1'b0, 1'b1);

    $display("[TB] byte-strobe merge");
    applyStimulus("t2 write", 64'h8000_0010, MSIZE8, 8'h0F, 64'hAAAA_AAAA_BBBB_BBBB,
                  64'h1122_3344_5566_7788, 1'b0, 1'b1);
    applyStimulus("t2 read", 64'h8000_0010, MSIZE8, 8'h00, 64'd0, 64'h1122_3344_BBBB_BBBB, 1'b0, 1'b1);

    $display("[TB] out of range");
    applyStimulus("t3 init w0", BASE, MSIZE8, 8'hFF, 64'hCAFE_F00D_DEAD_BEEF, 64'd0, 1'b0, 1'b0);
    applyStimulus("t3 below base", 64'h7FFF_FFF8, MSIZE8, 8'h00, 64'd0, 64'd0, 1'b1, 1'b1);
    applyStimulus("t3 past end", BASE + 64'(8 * MEM_WORDS), MSIZE8, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF,
                  64'd0, 1'b1, 1'b1);
    applyStimulus("t3 w0 intact", BASE, MSIZE8, 8'h00, 64'd0, 64'hCAFE_F00D_DEAD_BEEF, 1'b0, 1'b1);

    $display("[TB] misaligned");
    applyStimulus("t4 misaligned", 64'h8000_0002, MSIZE4, 8'h3C, 64'h0123_4567_89AB_CDEF, 64'd0, 1'b1, 1'b1);
    applyStimulus("t4 w0 intact", BASE, MSIZE8, 8'h00, 64'd0, 64'hCAFE_F00D_DEAD_BEEF, 1'b0, 1'b1);

    $display("[TB] reset mid-transaction");
    @(negedge clk);
    bus.dreq.valid  = 1'b1;
    bus.dreq.addr   = 64'h8000_0010;
    bus.dreq.size   = MSIZE8;
    bus.dreq.strobe = 8'hFF;
    bus.dreq.data   = 64'hDEAD_DEAD_DEAD_DEAD;
    @(negedge clk);
    reset = 1'b1;
    bus.dreq.valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    rstOks = 0;
    repeat (LATENCY + 4) begin
      @(negedge clk);
      if (bus.dresp.data_ok) rstOks++;
    end
    checkOutput("t5 no data_ok after reset", 64'(rstOks), 64'd0);
    applyStimulus("t5 word intact", 64'h8000_0010, MSIZE8, 8'h00, 64'd0, 64'h1122_3344_BBBB_BBBB, 1'b0, 1'b1);

    $display("[TB] valid held across three reads");
    repeat (3) expQ.push_back('{data: 64'h1122_3344_BBBB_BBBB, err: 1'b0, chkData: 1'b1});
    @(negedge clk);
    bus.dreq.valid  = 1'b1;
    bus.dreq.addr   = 64'h8000_0010;
    bus.dreq.size   = MSIZE8;
    bus.dreq.strobe = 8'h00;
    pulses = 0;
    cycles = 0;
    lastPulse = 0;
    while (pulses < 3 && cycles < 100) begin
      @(negedge clk);
      cycles++;
      if (bus.dresp.data_ok) begin
        pulses++;
        if (pulses > 1) begin
`ifdef DBUS_RESPONDER_RANDOM_DELAY_EN
          checkOutput("t6 pulse spacing 4..7", 64'((cycles - lastPulse) >= 4 && (cycles - lastPulse) <= 7), 64'd1);
`else
          checkOutput("t6 pulse spacing", 64'(cycles - lastPulse), 64'(LATENCY + 2));
`endif
        end
        lastPulse = cycles;
        if (pulses == 3) bus.dreq.valid = 1'b0;
      end
    end
    bus.dreq.valid = 1'b0;
    checkOutput("t6 pulse count", 64'(pulses), 64'd3);
    repeat (LATENCY + 8) @(negedge clk);

`ifdef DBUS_RESPONDER_RANDOM_DELAY_EN
    $display("[TB] random latency repeatability");
    doReset();
    for (int i = 0; i < 6; i++) begin
      applyStimulus("t6r run A", 64'h8000_0010, MSIZE8, 8'h00, 64'd0, 64'h1122_3344_BBBB_BBBB, 1'b0, 1'b1);
      latRunA.push_back(lastLatency);
    end
    doReset();
    for (int i = 0; i < 6; i++) begin
      applyStimulus("t6r run B", 64'h8000_0010, MSIZE8, 8'h00, 64'd0, 64'h1122_3344_BBBB_BBBB, 1'b0, 1'b1);
      latRunB.push_back(lastLatency);
    end
    for (int i = 0; i < 6; i++) begin
      checkOutput("t6r same latency after reset", 64'(latRunB[i]), 64'(latRunA[i]));
    end
`endif

    checkOutput("scoreboard drained", 64'(expQ.size()), 64'd0);
    $display("%0d/%0d checks passed", passedChecks, totalChecks);
    $finish;
  end

  // Hard stop in case a wait loop is ever left without a bound.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
